mem_log_trig: RTL

- Parametrised successor of the two-bank I/Q sample logger.
- Captures NUM_CH parallel channels of DATA_WIDTH-bit filter samples into one internal RAM of 2^ADDR_WIDTH words, each word NUM_CH*DATA_WIDTH bits wide.
- Two capture modes:
  - Linear fill: start, fill once, stop.
  - Triggered circular capture: a pre-trigger history plus a programmable post-trigger window.
- Sits between the filter output and the host read-out path. A frozen capture is read out in chronological order.

---
 rtl/mem_log_trig.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_log_trig.sv
// Multi-channel sample logger with linear-fill and triggered circular capture modes.
// A frozen capture is read out in chronological order through a one-cycle registered read port.
module mem_log_trig #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic                         i_valid,
    input  logic                         i_run_log,
    input  logic                         i_mode,
    input  logic                         i_trigger,
    input  logic [ADDR_WIDTH-1:0]        i_post_count,
    input  logic [ADDR_WIDTH-1:0]        i_addr_log_to_mem,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data_log_from_mem,
    output logic                         o_mem_full,
    output logic                         o_triggered,
    output logic                         o_busy,
    output logic [ADDR_WIDTH:0]          o_fill_count
);

    localparam int unsigned Width = NUM_CH * DATA_WIDTH;
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FillMax = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH-1:0] PostOne = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {StIdle, StRun, StArmed, StPost, StFull} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     fill_q, fill_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic [ADDR_WIDTH-1:0]   post_q, post_d;
    logic                    trig_q, trig_d;
    logic [Width-1:0]        rd_data_q;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    logic [Width-1:0] mem_q [Depth];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        post_d   = post_q;
        trig_d   = trig_q;
        wr_en    = 1'b0;

        if (i_run_log) begin
            state_d  = i_mode ? StArmed : StRun;
            wr_ptr_d = '0;
            fill_d   = '0;
            post_d   = '0;
            trig_d   = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (i_valid) begin
                        wr_en = 1'b1;
                        if (&wr_ptr_q) state_d = StFull;
                    end
                end
                StArmed: begin
                    if (i_trigger) begin
                        trig_d = 1'b1;
                        post_d = i_post_count;
                        if (i_post_count == '0) begin
                            state_d = StFull;
                        end else if (i_valid) begin
                            // Trigger-cycle sample is post sample #1.
                            wr_en   = 1'b1;
                            post_d  = i_post_count - PostOne;
                            state_d = (i_post_count == PostOne) ? StFull : StPost;
                        end else begin
                            state_d = StPost;
                        end
                    end else if (i_valid) begin
                        wr_en = 1'b1;
                    end
                end
                StPost: begin
                    if (i_valid) begin
                        wr_en  = 1'b1;
                        post_d = post_q - PostOne;
                        if (post_q == PostOne) state_d = StFull;
                    end
                end
                default: ;
            endcase
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PostOne;
            if (fill_q != FillMax) fill_d = fill_q + (ADDR_WIDTH + 1)'(1);
        end

        // Once wrapped, the oldest sample sits at the next write location.
        start_d = (fill_d == FillMax) ? wr_ptr_d : '0;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            start_q  <= '0;
            post_q   <= '0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            start_q  <= start_d;
            post_q   <= post_d;
            trig_q   <= trig_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= i_data;
    end

    assign rd_addr = start_q + i_addr_log_to_mem;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_q <= '0;
        end else if (state_q == StFull) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign o_data_log_from_mem = rd_data_q;
    assign o_mem_full          = (state_q == StFull);
    assign o_busy              = (state_q == StRun) || (state_q == StArmed) || (state_q == StPost);
    assign o_triggered         = trig_q;
    assign o_fill_count        = fill_q;

endmodule
